// File: rtl/spy_bus_ctl.sv
// spy_bus_ctl
//
// Sequencer for the CADR spy/debug bus. It runs one read or one write
// transaction at a time for a debug host: it drives a one-hot spy register
// select, holds it for a programmable setup time, pulses dbread or dbwrite
// for a programmable strobe width, keeps the select for one hold cycle, and
// then acknowledges. Reads capture the spy bus at the end of the strobe.
//
// Parameters:
//   SETUP_CYC  - cycles the select is held before the strobe asserts (1..255)
//   STROBE_CYC - cycles dbread/dbwrite stays asserted (1..255)
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   req        in   transaction request, only looked at while busy=0
//   wr         in   1=write, 0=read (sampled with req)
//   addr[4:0]  in   spy register address (sampled with req)
//   wdata[15:0]in   write data (sampled with req)
//   busy       out  transaction in progress
//   ack        out  one-cycle completion pulse
//   rdata[15:0]out  most recently captured read data
//   spy_sel[31:0] out one-hot spy register select
//   dbread     out  spy read strobe
//   dbwrite    out  spy write strobe
//   spy_wdata[15:0] out data presented to the spy write decoders
//   spy_in[15:0] in  spy bus read data from the read mux

module spy_bus_ctl #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [4:0]  addr,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        ack,
  output logic [15:0] rdata,
  output logic [31:0] spy_sel,
  output logic        dbread,
  output logic        dbwrite,
  output logic [15:0] spy_wdata,
  input  logic [15:0] spy_in
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_STROBE = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Counter reload values: a phase lasting N cycles counts N-1 down to 0.
  localparam logic [7:0] SETUP_LOAD  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LOAD = 8'(STROBE_CYC - 1);

  logic [2:0] state;
  logic [7:0] cnt;
  logic       wr_q;

  // All outputs are registered and are updated on the same edge that moves
  // the FSM into the state they belong to, so the select is already valid in
  // the first SETUP cycle and the ack lines up with the DONE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= 8'd0;
      wr_q      <= 1'b0;
      busy      <= 1'b0;
      ack       <= 1'b0;
      rdata     <= 16'h0000;
      spy_sel   <= 32'h0000_0000;
      dbread    <= 1'b0;
      dbwrite   <= 1'b0;
      spy_wdata <= 16'h0000;
    end else begin
      ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          if (req) begin
            state     <= ST_SETUP;
            cnt       <= SETUP_LOAD;
            wr_q      <= wr;
            busy      <= 1'b1;
            spy_sel   <= 32'd1 << addr;
            spy_wdata <= wr ? wdata : 16'h0000;
          end
        end

        ST_SETUP: begin
          if (cnt == 8'd0) begin
            state   <= ST_STROBE;
            cnt     <= STROBE_LOAD;
            dbread  <= ~wr_q;
            dbwrite <= wr_q;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        ST_STROBE: begin
          // The read capture happens on the edge that closes the strobe,
          // giving the read mux the full strobe width to settle.
          if (cnt == 8'd0) begin
            state   <= ST_HOLD;
            dbread  <= 1'b0;
            dbwrite <= 1'b0;
            if (!wr_q) begin
              rdata <= spy_in;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        ST_HOLD: begin
          // Select and write data stay put through HOLD for decoder hold
          // time; they drop as DONE is entered.
          state     <= ST_DONE;
          ack       <= 1'b1;
          spy_sel   <= 32'h0000_0000;
          spy_wdata <= 16'h0000;
        end

        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          spy_sel   <= 32'h0000_0000;
          spy_wdata <= 16'h0000;
          dbread    <= 1'b0;
          dbwrite   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spy_bus_ctl.sv
// tb_spy_bus_ctl
//
// Bench for spy_bus_ctl. Two instances share clock, reset and data inputs:
// dut_a uses SETUP_CYC=1/STROBE_CYC=2, dut_b uses SETUP_CYC=2/STROBE_CYC=3,
// each with its own req. A cycle-by-cycle vector table covers a read, a
// capture-edge read and a write; hand-written sequences cover held req,
// mid-transaction reset and back-to-back reads of every address.

module tb_spy_bus_ctl;

  logic        clk;
  logic        reset;
  logic        wr;
  logic [4:0]  addr;
  logic [15:0] wdata;
  logic [15:0] spy_in;
  logic        req_a, req_b;

  logic        busy_a, ack_a, dbread_a, dbwrite_a;
  logic [15:0] rdata_a, spy_wdata_a;
  logic [31:0] spy_sel_a;
  logic        busy_b, ack_b, dbread_b, dbwrite_b;
  logic [15:0] rdata_b, spy_wdata_b;
  logic [31:0] spy_sel_b;

  int n_cmp;
  int n_err;

  spy_bus_ctl #(.SETUP_CYC(1), .STROBE_CYC(2)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .wr(wr), .addr(addr),
    .wdata(wdata), .busy(busy_a), .ack(ack_a), .rdata(rdata_a),
    .spy_sel(spy_sel_a), .dbread(dbread_a), .dbwrite(dbwrite_a),
    .spy_wdata(spy_wdata_a), .spy_in(spy_in)
  );

  spy_bus_ctl #(.SETUP_CYC(2), .STROBE_CYC(3)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .wr(wr), .addr(addr),
    .wdata(wdata), .busy(busy_b), .ack(ack_b), .rdata(rdata_b),
    .spy_sel(spy_sel_b), .dbread(dbread_b), .dbwrite(dbwrite_b),
    .spy_wdata(spy_wdata_b), .spy_in(spy_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          use_b;
    logic        req;
    logic        wr;
    logic [4:0]  addr;
    logic [15:0] wdata;
    logic [15:0] spy_in;
    logic        e_busy;
    logic        e_ack;
    logic        e_rd;
    logic        e_wr;
    logic [31:0] e_sel;
    logic [15:0] e_wdata;
    logic [15:0] e_rdata;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(bit b, logic rq, logic w, logic [4:0] ad,
                              logic [15:0] wd, logic [15:0] si,
                              logic eb, logic ea, logic er, logic ew,
                              logic [31:0] es, logic [15:0] ewd,
                              logic [15:0] erd);
    vec_t v;
    v.use_b = b;   v.req = rq;   v.wr = w;     v.addr = ad;
    v.wdata = wd;  v.spy_in = si;
    v.e_busy = eb; v.e_ack = ea; v.e_rd = er;  v.e_wr = ew;
    v.e_sel = es;  v.e_wdata = ewd; v.e_rdata = erd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Checks the selected instance's outputs for the current cycle, then
  // drives the inputs that the next rising edge will see.
  task automatic applyStimulus(input int idx, input vec_t v);
    logic        o_busy, o_ack, o_rd, o_wr;
    logic [31:0] o_sel;
    logic [15:0] o_wd, o_rdata;
    o_busy  = v.use_b ? busy_b      : busy_a;
    o_ack   = v.use_b ? ack_b       : ack_a;
    o_rd    = v.use_b ? dbread_b    : dbread_a;
    o_wr    = v.use_b ? dbwrite_b   : dbwrite_a;
    o_sel   = v.use_b ? spy_sel_b   : spy_sel_a;
    o_wd    = v.use_b ? spy_wdata_b : spy_wdata_a;
    o_rdata = v.use_b ? rdata_b     : rdata_a;
    checkOutput($sformatf("v%0d busy", idx),      32'(o_busy),  32'(v.e_busy));
    checkOutput($sformatf("v%0d ack", idx),       32'(o_ack),   32'(v.e_ack));
    checkOutput($sformatf("v%0d dbread", idx),    32'(o_rd),    32'(v.e_rd));
    checkOutput($sformatf("v%0d dbwrite", idx),   32'(o_wr),    32'(v.e_wr));
    checkOutput($sformatf("v%0d spy_sel", idx),   o_sel,        v.e_sel);
    checkOutput($sformatf("v%0d spy_wdata", idx), 32'(o_wd),    32'(v.e_wdata));
    checkOutput($sformatf("v%0d rdata", idx),     32'(o_rdata), 32'(v.e_rdata));
    req_a  = v.use_b ? 1'b0 : v.req;
    req_b  = v.use_b ? v.req : 1'b0;
    wr     = v.wr;
    addr   = v.addr;
    wdata  = v.wdata;
    spy_in = v.spy_in;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int ack_cnt;
    bit got_ack;
    logic [31:0] one;

    n_cmp = 0;
    n_err = 0;

    // Read on dut_a: addr 5, spy_in A55A (SETUP=1, STROBE=2).
    vecs[0]  = mk(0,1,0,5,16'h0,16'hA55A, 0,0,0,0,32'h0,16'h0,16'h0);
    vecs[1]  = mk(0,0,0,5,16'h0,16'hA55A, 1,0,0,0,32'h20,16'h0,16'h0);
    vecs[2]  = mk(0,0,0,5,16'h0,16'hA55A, 1,0,1,0,32'h20,16'h0,16'h0);
    vecs[3]  = mk(0,0,0,5,16'h0,16'hA55A, 1,0,1,0,32'h20,16'h0,16'h0);
    vecs[4]  = mk(0,0,0,5,16'h0,16'hA55A, 1,0,0,0,32'h20,16'h0,16'hA55A);
    vecs[5]  = mk(0,0,0,5,16'h0,16'hA55A, 1,1,0,0,32'h0,16'h0,16'hA55A);
    vecs[6]  = mk(0,0,0,5,16'h0,16'hA55A, 0,0,0,0,32'h0,16'h0,16'hA55A);
    // Capture-edge read on dut_b: addr 3, spy_in changes late in STROBE
    // and again during HOLD.
    vecs[7]  = mk(1,1,0,3,16'h0,16'h0001, 0,0,0,0,32'h0,16'h0,16'h0);
    vecs[8]  = mk(1,0,0,3,16'h0,16'h0001, 1,0,0,0,32'h8,16'h0,16'h0);
    vecs[9]  = mk(1,0,0,3,16'h0,16'h0001, 1,0,0,0,32'h8,16'h0,16'h0);
    vecs[10] = mk(1,0,0,3,16'h0,16'h0001, 1,0,1,0,32'h8,16'h0,16'h0);
    vecs[11] = mk(1,0,0,3,16'h0,16'h0001, 1,0,1,0,32'h8,16'h0,16'h0);
    vecs[12] = mk(1,0,0,3,16'h0,16'hBEEF, 1,0,1,0,32'h8,16'h0,16'h0);
    vecs[13] = mk(1,0,0,3,16'h0,16'h0000, 1,0,0,0,32'h8,16'h0,16'hBEEF);
    vecs[14] = mk(1,0,0,3,16'h0,16'h0000, 1,1,0,0,32'h0,16'h0,16'hBEEF);
    // Write on dut_b: addr 31, wdata 1234 (SETUP=2, STROBE=3).
    vecs[15] = mk(1,1,1,31,16'h1234,16'h0, 0,0,0,0,32'h0,16'h0,16'hBEEF);
    vecs[16] = mk(1,0,1,31,16'h1234,16'h0, 1,0,0,0,32'h8000_0000,16'h1234,16'hBEEF);
    vecs[17] = mk(1,0,1,31,16'h1234,16'h0, 1,0,0,0,32'h8000_0000,16'h1234,16'hBEEF);
    vecs[18] = mk(1,0,1,31,16'h1234,16'h0, 1,0,0,1,32'h8000_0000,16'h1234,16'hBEEF);
    vecs[19] = mk(1,0,1,31,16'h1234,16'h0, 1,0,0,1,32'h8000_0000,16'h1234,16'hBEEF);
    vecs[20] = mk(1,0,1,31,16'h1234,16'h0, 1,0,0,1,32'h8000_0000,16'h1234,16'hBEEF);
    vecs[21] = mk(1,0,1,31,16'h1234,16'h0, 1,0,0,0,32'h8000_0000,16'h1234,16'hBEEF);
    vecs[22] = mk(1,0,1,31,16'h1234,16'h0, 1,1,0,0,32'h0,16'h0,16'hBEEF);
    vecs[23] = mk(1,0,1,31,16'h1234,16'h0, 0,0,0,0,32'h0,16'h0,16'hBEEF);

    reset  = 1'b1;
    req_a  = 1'b0;
    req_b  = 1'b0;
    wr     = 1'b0;
    addr   = 5'd0;
    wdata  = 16'h0;
    spy_in = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset busy_a",   32'(busy_a),   32'd0);
    checkOutput("reset ack_a",    32'(ack_a),    32'd0);
    checkOutput("reset sel_a",    spy_sel_a,     32'd0);
    checkOutput("reset rdata_a",  32'(rdata_a),  32'd0);
    checkOutput("reset strobe_b", 32'({dbread_b, dbwrite_b}), 32'd0);
    checkOutput("reset wdata_b",  32'(spy_wdata_b), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      applyStimulus(i, vecs[i]);
      @(negedge clk);
    end
    req_a = 1'b0;
    req_b = 1'b0;
    wr    = 1'b0;
    wdata = 16'h0;

    // Held req on dut_a: addr changes while busy must not move the select;
    // the still-high req starts a second transaction two cycles after ack.
    $display("[TB] held req sequence");
    req_a  = 1'b1;
    addr   = 5'd2;
    spy_in = 16'h0002;
    @(negedge clk);
    addr    = 5'd9;
    ack_cnt = 0;
    for (int c = 0; c <= 6; c++) begin
      if (c <= 3)      one = 32'h4;
      else if (c == 6) one = 32'h200;
      else             one = 32'h0;
      checkOutput($sformatf("held c%0d sel", c), spy_sel_a, one);
      checkOutput($sformatf("held c%0d ack", c), 32'(ack_a), (c == 4) ? 32'd1 : 32'd0);
      if (ack_a) ack_cnt++;
      if (c == 6) req_a = 1'b0;
      @(negedge clk);
    end
    checkOutput("held first acks", 32'(ack_cnt), 32'd1);
    ack_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (ack_a) ack_cnt++;
      @(negedge clk);
    end
    checkOutput("held second acks", 32'(ack_cnt), 32'd1);
    checkOutput("held idle busy",   32'(busy_a),  32'd0);
    checkOutput("held rdata",       32'(rdata_a), 32'h0002);

    // Reset during STROBE of a read on dut_a.
    $display("[TB] mid-transaction reset");
    req_a  = 1'b1;
    addr   = 5'd6;
    spy_in = 16'h1111;
    @(negedge clk);
    req_a = 1'b0;
    @(negedge clk);
    checkOutput("rst pre dbread", 32'(dbread_a), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst dbread", 32'(dbread_a), 32'd0);
    checkOutput("rst sel",    spy_sel_a,     32'd0);
    checkOutput("rst busy",   32'(busy_a),   32'd0);
    checkOutput("rst rdata",  32'(rdata_a),  32'd0);
    checkOutput("rst ack",    32'(ack_a),    32'd0);
    ack_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ack_a) ack_cnt++;
    end
    checkOutput("rst no ack", 32'(ack_cnt), 32'd0);
    req_a  = 1'b1;
    addr   = 5'd0;
    spy_in = 16'h5A5A;
    @(negedge clk);
    req_a = 1'b0;
    checkOutput("fresh sel", spy_sel_a, 32'h1);
    repeat (4) @(negedge clk);
    checkOutput("fresh ack",   32'(ack_a),   32'd1);
    checkOutput("fresh rdata", 32'(rdata_a), 32'h5A5A);
    @(negedge clk);

    // Back-to-back reads of every address with spy_in = addr.
    $display("[TB] address sweep");
    for (int a = 0; a < 32; a++) begin
      req_a  = 1'b1;
      addr   = 5'(a);
      spy_in = 16'(a);
      @(negedge clk);
      req_a = 1'b0;
      one   = 32'd1 << a;
      checkOutput($sformatf("sweep %0d sel", a), spy_sel_a, one);
      got_ack = 1'b0;
      for (int k = 0; k < 20; k++) begin
        checkOutput($sformatf("sweep %0d onehot", a), 32'($onehot0(spy_sel_a)), 32'd1);
        if (ack_a) begin
          got_ack = 1'b1;
          break;
        end
        @(negedge clk);
      end
      checkOutput($sformatf("sweep %0d ack seen", a), 32'(got_ack), 32'd1);
      checkOutput($sformatf("sweep %0d rdata", a), 32'(rdata_a), 32'(a));
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spy_bus_ctl.md
Name: spy_bus_ctl

Overview:
Sequencer for the CADR spy/debug bus. It accepts single read or write transactions from a host-side debug port (serial/USB bridge or boot FSM) and drives the one-hot spy register selects plus the dbread/dbwrite strobes with programmable setup and strobe widths. For reads, it captures the 16-bit spy bus and returns it with a one-cycle ack. It sits between the debug host interface and the spy read mux and spy write decoders.

Parameters:
SETUP_CYC, 1, cycles select is held before strobe asserts (1..255)
STROBE_CYC, 2, cycles dbread/dbwrite is held asserted (1..255)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
req  input  1  host transaction request, sampled only when busy=0
wr  input  1  1=write, 0=read; sampled with req
addr  input  5  spy register address; sampled with req
wdata  input  16  write data; sampled with req
busy  output  1  transaction in progress; new req ignored while high
ack  output  1  one-cycle pulse, transaction complete
rdata  output  16  last captured read data
spy_sel  output  32  one-hot spy register select, bit = latched addr
dbread  output  1  spy read strobe
dbwrite  output  1  spy write strobe
spy_wdata  output  16  data driven to spy write decoders
spy_in  input  16  spy bus read data (spy_out of the read mux)

Behaviour:
- States: IDLE, SETUP, STROBE, HOLD, DONE. An 8-bit down-counter times SETUP and STROBE.
- Reset (synchronous, any state): state=IDLE. busy=0, ack=0, rdata=0, spy_sel=0, dbread=0, dbwrite=0, spy_wdata=0, counter=0.
- IDLE: busy=0, all strobes low, spy_sel=0. On a clock edge with req=1, latch addr/wr/wdata, load counter=SETUP_CYC-1, go to SETUP.
- SETUP: busy=1, spy_sel=onehot(addr_q), spy_wdata=wdata_q for a write (0 for a read). Stays SETUP_CYC cycles, then loads counter=STROBE_CYC-1 and goes to STROBE.
- STROBE: spy_sel is held. dbread=1 for a read, dbwrite=1 for a write, never both. Stays STROBE_CYC cycles.
  - Read: on the edge that ends the last STROBE cycle, rdata <= spy_in.
- HOLD: one cycle. spy_sel and spy_wdata are still held, strobes are low (hold time for write decoders).
- DONE: one cycle. ack=1, busy=1, spy_sel=0, spy_wdata=0. Next state is IDLE.
- Latency: ack is high in cycle SETUP_CYC+STROBE_CYC+1, counting the cycle after the accepting edge as cycle 0. The next req can be accepted on the edge ending DONE's following IDLE cycle. Minimum spacing between accepts is SETUP_CYC+STROBE_CYC+3 cycles.
- req while busy=1: ignored, not queued. Any held req is re-sampled in IDLE.
- rdata: changes only on a read capture. Writes and ack do not alter it, and it holds across idle time.
- Outputs are registered. spy_sel is exactly one-hot or zero, never multi-hot.
- All 32 addresses are legal. Decode meaning belongs to the consumers.
- Reset mid-transaction: all strobes and selects drop on the next edge and no ack is produced.

Test Plan:
- Read, SETUP=1, STROBE=2: req with addr=5, spy_in=16'hA55A.
  - spy_sel=32'h20 in cycles 0-3.
  - dbread high in cycles 1-2.
  - ack in cycle 4 with rdata=16'hA55A. busy deasserts in cycle 5.
- Write, SETUP=2, STROBE=3: req wr=1 addr=31 wdata=16'h1234.
  - spy_sel=32'h8000_0000 and spy_wdata=16'h1234 in cycles 0-5.
  - dbwrite high in cycles 2-4, dbread never high.
  - ack in cycle 6. rdata unchanged from its prior value.
- Capture edge: change spy_in from 16'h0001 to 16'hBEEF mid-STROBE -> rdata=16'hBEEF. Change it again during HOLD -> rdata unaffected.
- req pulses during SETUP/STROBE/DONE: no extra ack, no select change. A held req produces a second transaction whose sel appears 2 cycles after the first ack.
- Reset asserted in STROBE of a read -> next cycle dbread=0, spy_sel=0, busy=0, rdata=0, no ack. A fresh read of addr 0 then completes normally with spy_sel=32'h1.
- Back-to-back reads addr 0..31 with spy_in=addr -> each ack returns rdata=addr, and spy_sel is one-hot at every cycle.
